// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between the fetch side, decode_stage and execute.
// master = upstream/downstream environment, slave = decode_stage.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [3:0]      out_func3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_func7;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic            out_reg_we;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_func3,
               out_rs1, out_rs2, out_func7, out_imm, out_fmt, out_illegal, out_reg_we
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_func3,
               out_rs1, out_rs2, out_func7, out_imm, out_fmt, out_illegal, out_reg_we
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides, flush and backpressure.
// DECODE_SKID_EN adds a one-entry skid register and a registered in_ready.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    decode_stage_if.slave   bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_INV = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [3:0]      func3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic            reg_we;
    } dec_t;

    dec_t        dec;
    dec_t        out_q;
    logic        out_valid_q;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic        writes_rd;
    logic        accept;

    assign inst = bus.in_inst;

    // Opcodes with inst[1:0] != 2'b11 never match a case item, so they land on INV.
    always_comb begin
        dec         = '0;
        imm32       = '0;
        writes_rd   = 1'b0;
        dec.pc      = bus.in_pc;
        dec.opcode  = inst[6:0];
        dec.rd      = inst[11:7];
        dec.func3   = {inst[30], inst[14:12]};
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.func7   = inst[31:25];
        dec.fmt     = FMT_INV;
        dec.illegal = 1'b1;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U; dec.illegal = 1'b0; writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec.fmt = FMT_J; dec.illegal = 1'b0; writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                dec.fmt = FMT_I; dec.illegal = 1'b0; writes_rd = 1'b1;
            end
            OPC_MISC: begin
                dec.fmt = FMT_I; dec.illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                dec.fmt = FMT_I; dec.illegal = 1'b0; writes_rd = (inst[14:12] != 3'b000);
            end
            OPC_STORE: begin
                dec.fmt = FMT_S; dec.illegal = 1'b0;
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B; dec.illegal = 1'b0;
            end
            OPC_OP: begin
                dec.fmt = FMT_R; dec.illegal = 1'b0; writes_rd = 1'b1;
            end
            default: ;
        endcase
        case (dec.fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm    = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        dec.reg_we = writes_rd && (inst[11:7] != 5'd0);
    end

    assign accept = bus.in_valid && bus.in_ready;

`ifdef DECODE_SKID_EN
    dec_t skid_q;
    logic skid_valid_q;
    logic in_ready_q;

    assign bus.in_ready = in_ready_q;

    // in_ready_q mirrors "skid empty next cycle"; accepts only happen with the skid empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (out_valid_q && !bus.out_ready) begin
            if (accept) begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end else if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q <= accept;
            if (accept) out_q <= dec;
            in_ready_q  <= 1'b1;
        end
    end
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_opcode  = out_q.opcode;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_func3   = out_q.func3;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_func7   = out_q.func7;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_reg_we  = out_q.reg_we;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; a 64-bit-immediate copy shares the stimulus.
// Expectations adapt to DECODE_SKID_EN.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();
    decode_stage_if #(.XLEN(64), .PC_W(32)) bus64 ();

    assign bus64.in_valid  = bus.in_valid;
    assign bus64.in_inst   = bus.in_inst;
    assign bus64.in_pc     = bus.in_pc;
    assign bus64.out_ready = bus.out_ready;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );
    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64)
    );

`ifdef DECODE_SKID_EN
    localparam int       EXP_ACC = 2;
    localparam logic     RDY_RST = 1'b0;
`else
    localparam int       EXP_ACC = 1;
    localparam logic     RDY_RST = 1'b1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        tick();
    endtask

    function automatic logic [31:0] addi(input int n);
        return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
    endfunction

    logic [31:0] stream [4];
    logic [31:0] got_imm [$];
    int          idx;
    int          acc;
    int          ghosts;
    logic        fire_in;
    logic        fire_out;

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_pc", bus.out_pc, 0);
        check("rst_imm", bus.out_imm, 0);
        check("rst_fmt", bus.out_fmt, 0);
        check("rst_we", bus.out_reg_we, 0);
        check("rst_in_ready", bus.in_ready, RDY_RST);

        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);
        check("idle_valid", bus.out_valid, 0);

        // Back-to-back directed vectors with out_ready high.
        send(32'hFFF00093, 32'h100);
        check("addi_valid", bus.out_valid, 1);
        check("addi_fmt", bus.out_fmt, 1);
        check("addi_imm", bus.out_imm, 64'hFFFF_FFFF);
        check("addi_rd", bus.out_rd, 1);
        check("addi_we", bus.out_reg_we, 1);
        check("addi_ill", bus.out_illegal, 0);
        check("addi_pc", bus.out_pc, 32'h100);

        send(32'h402081B3, 32'h104);
        check("sub_valid", bus.out_valid, 1);
        check("sub_fmt", bus.out_fmt, 0);
        check("sub_func3", bus.out_func3, 4'b1000);
        check("sub_func7", bus.out_func7, 7'h20);
        check("sub_imm", bus.out_imm, 0);
        check("sub_we", bus.out_reg_we, 1);
        check("sub_rd", bus.out_rd, 3);
        check("sub_rs1", bus.out_rs1, 1);
        check("sub_rs2", bus.out_rs2, 2);
        check("sub_opcode", bus.out_opcode, 7'h33);

        send(32'hFE000EE3, 32'h108);
        check("beq_fmt", bus.out_fmt, 3);
        check("beq_imm", bus.out_imm, 64'hFFFF_FFFC);
        check("beq_we", bus.out_reg_we, 0);
        check("beq_rd_raw", bus.out_rd, 29);
        check("beq_imm64", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_fmt64", bus64.out_fmt, 3);

        send(32'h00000000, 32'h10C);
        check("zero_fmt", bus.out_fmt, 7);
        check("zero_ill", bus.out_illegal, 1);
        check("zero_we", bus.out_reg_we, 0);
        check("zero_imm", bus.out_imm, 0);

        send(32'h123452B7, 32'h110);
        check("lui_fmt", bus.out_fmt, 4);
        check("lui_imm", bus.out_imm, 32'h1234_5000);
        check("lui_we", bus.out_reg_we, 1);

        send(32'hFE20AC23, 32'h114);
        check("sw_fmt", bus.out_fmt, 2);
        check("sw_imm", bus.out_imm, 64'hFFFF_FFF8);
        check("sw_we", bus.out_reg_we, 0);

        send(32'h008000EF, 32'h118);
        check("jal_fmt", bus.out_fmt, 5);
        check("jal_imm", bus.out_imm, 8);
        check("jal_we", bus.out_reg_we, 1);

        send(32'h000010F3, 32'h11C);
        check("csrrw_fmt", bus.out_fmt, 1);
        check("csrrw_we", bus.out_reg_we, 1);

        send(32'h00000073, 32'h120);
        check("ecall_we", bus.out_reg_we, 0);
        check("ecall_ill", bus.out_illegal, 0);

        send(32'h00000012, 32'h124);
        check("low2_ill", bus.out_illegal, 1);
        check("low2_fmt", bus.out_fmt, 7);

        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", bus.out_valid, 0);

        // Stall: stream four ADDIs with out_ready low for three cycles.
        for (int k = 0; k < 4; k++) stream[k] = addi(k + 1);
        idx = 0; acc = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = (idx < 4);
            bus.in_inst  = (idx < 4) ? stream[idx] : 32'h0;
            bus.in_pc    = 32'h200 + 32'(idx * 4);
            #1;
            fire_in = bus.in_valid && bus.in_ready;
            tick();
            if (fire_in) begin idx++; acc++; end
            if (c > 0) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_pc", bus.out_pc, 32'h200);
                check("hold_imm", bus.out_imm, 1);
            end
        end
        check("stall_accepts", acc, EXP_ACC);
        check("stall_in_ready", bus.in_ready, 0);

        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got_imm.size() < 4; c++) begin
            bus.in_valid = (idx < 4);
            bus.in_inst  = (idx < 4) ? stream[idx] : 32'h0;
            bus.in_pc    = 32'h200 + 32'(idx * 4);
            #1;
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) got_imm.push_back(bus.out_imm);
            tick();
            if (fire_in) idx++;
        end
        check("stream_count", got_imm.size(), 4);
        for (int k = 0; k < 4; k++)
            check("stream_order", (k < got_imm.size()) ? got_imm[k] : 32'hxxxx_xxxx, k + 1);
        bus.in_valid = 1'b0;
        tick();

        // Flush with output (and skid when present) full and a new input offered.
        bus.out_ready = 1'b0;
        send(addi(5), 32'h300);
        send(addi(6), 32'h304);
        check("flush_pre_valid", bus.out_valid, 1);
        bus.in_inst = addi(7); bus.in_pc = 32'h308;
        flush = 1'b1; bus.out_ready = 1'b1;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        ghosts = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_valid) ghosts++;
        end
        check("flush_no_ghost", ghosts, 0);
        send(addi(8), 32'h30C);
        check("post_flush_imm", bus.out_imm, 8);
        check("post_flush_pc", bus.out_pc, 32'h30C);
        bus.in_valid = 1'b0;
        tick();

        // Mid-stream reset: same fill, rst_n low for one cycle.
        bus.out_ready = 1'b0;
        send(addi(9), 32'h400);
        send(addi(10), 32'h404);
        check("rst2_pre_valid", bus.out_valid, 1);
        bus.in_inst = addi(11); bus.in_pc = 32'h408;
        rst_n = 1'b0; bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1; bus.in_valid = 1'b0;
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_pc", bus.out_pc, 0);
        check("rst2_in_ready", bus.in_ready, RDY_RST);
        ghosts = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_valid) ghosts++;
        end
        check("rst2_no_ghost", ghosts, 0);
        check("rst2_ready_after", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
